sobel_stream: RTL and testbench
===============================

// Module: sobel_stream
// PURPOSE
//  Streaming 3x3 Sobel edge detector for raster-order pixel streams. Replaces the
//  pure combinational 8-neighbour datapath with internal line buffers, a window
//  shifter and a 2-stage pipeline.
//  Sits between the pixel source (camera/DMA) and the edge-map sink, with
//  valid/ready flow control on both sides.
// PARAMETERS
//  IMG_W   64  pixels per line (>=3)
//  IMG_H   48  lines per frame (>=3)
//  PIX_W   8   pixel bit width; magnitude width MAG_W = PIX_W+3
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      async active-low reset
//  s_valid    in   1      input pixel valid
//  s_ready    out  1      block accepts pixel when s_valid&&s_ready
//  s_sof      in   1      qualifies first pixel of a frame (sampled on accept)
//  s_pix      in   PIX_W  pixel, raster order
//  threshold  in   MAG_W  edge threshold, static during a frame
//  m_valid    out  1      output result valid
//  m_ready    in   1      sink accepts when m_valid&&m_ready
//  m_mag      out  MAG_W  |gx|+|gy|
//  m_edge     out  1      1 when m_mag > threshold (strict)
//  m_eof      out  1      marks last result of a frame
// BEHAVIOUR
//  - Reset: s_ready=0 while rst_n low, 1 in the first cycle after release; m_valid=0,
//    m_mag=0, m_edge=0, m_eof=0. Counters and window are cleared; line-buffer RAM
//    contents are don't-care.
//  - Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accept. An accept
//    with s_sof=1 forces the pixel to col=0,row=0 whether or not that is the expected
//    position; the partial frame is dropped with no m_eof.
//  - Pixels after the last pixel of the frame and before the next s_sof: accepted and
//    discarded.
//  - Storage: two line buffers of IMG_W x PIX_W in a rotating pair. 3x3 window regs
//    p0..p8: p0 = top-left, p4 = centre, p8 = bottom-right = newest pixel.
//    Window shifts on every accept.
//  - Result produced only for interior centres: accept at row>=2 and col>=2
//    (centre = row-1, col-1). That is (IMG_W-2)*(IMG_H-2) results per frame.
//    No border outputs.
//  - Arithmetic: signed, width MAG_W+1, exact (no truncation).
//      gx = (p2+2p5+p8)-(p0+2p3+p6)
//      gy = (p0+2p1+p2)-(p6+2p7+p8)
//      m_mag = |gx|+|gy|, true two's-complement abs (not one's complement).
//    Max 8*(2^PIX_W-1) fits MAG_W; no saturation needed.
//  - Pipeline: S1 registers gx,gy; S2 registers m_mag/m_edge/m_eof/m_valid.
//    Latency = 2 cycles from accepting p8 to m_valid, with no stall.
//  - Flow control: global stall = m_valid && !m_ready.
//    s_ready = !stall; registers and counters freeze during a stall.
//    Outputs hold stable while m_valid=1 and m_ready=0.
//    Simultaneous accept and output handshake in one cycle is legal: full throughput,
//    1 pixel/clk.
//  - m_eof=1 with the result whose centre is (IMG_H-2, IMG_W-2).
//  - Reset mid-frame: immediate clear, no pending result emitted.
//  - Changing threshold mid-frame: affects only results entering S2 afterwards.
// TESTING (IMG_W=8, IMG_H=5, PIX_W=8 unless noted)
//  1. Flat frame, all pixels 100, m_ready=1
//     -> exactly 18 results, all m_mag=0, m_edge=0; m_eof on the 18th only.
//  2. Vertical step: cols 0-3 =0, cols 4-7 =255, threshold=500
//     -> per row, centre cols 3,4 give m_mag=1020, m_edge=1; others 0.
//  3. Threshold boundary: same image, threshold=1020 -> m_edge=0 everywhere;
//     threshold=1019 -> m_edge=1 at cols 3,4.
//  4. Backpressure: random m_ready at 30% duty, s_valid random
//     -> result sequence identical to test 2; outputs stable while stalled;
//        no loss or duplication.
//  5. s_sof asserted mid-frame (row 2, col 5)
//     -> old frame dropped, no m_eof; new full frame gives 18 correct results.
//  6. rst_n pulsed low while m_valid=1 and stalled -> m_valid=0 asynchronously;
//     the next frame after release is correct.

Source files
------------

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: rotating line-buffer pair, 3x3 window shifter,
// two-stage gradient/magnitude pipeline, valid/ready flow control on both sides.
module sobel_stream #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 48,
  parameter int unsigned PIX_W = 8,
  localparam int unsigned MAG_W = PIX_W + 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sof,
  input  logic [PIX_W-1:0] s_pix,
  input  logic [MAG_W-1:0] threshold,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [MAG_W-1:0] m_mag,
  output logic             m_edge,
  output logic             m_eof
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned SW = MAG_W + 1;

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] win [9];
  logic             sel;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             done;
  logic             win_v, win_eof;
  logic signed [SW-1:0] gx, gy;
  logic             s1_v, s1_eof;

  logic             stall, accept, live;
  logic [CW-1:0]    cur_col;
  logic [RW-1:0]    cur_row;
  logic             last_col, last_row;
  logic [PIX_W-1:0] top, mid;
  logic signed [SW-1:0] e [9];
  logic signed [SW-1:0] gx_c, gy_c, ax, ay;
  logic [MAG_W-1:0] mag_c;

  // Handshake and raster position; s_sof relocates the incoming pixel to (0,0)
  always_comb begin
    stall    = m_valid && !m_ready;
    s_ready  = rst_n && !stall;
    accept   = s_valid && s_ready;
    live     = accept && (s_sof || !done);
    cur_col  = s_sof ? '0 : col;
    cur_row  = s_sof ? '0 : row;
    last_col = (cur_col == CW'(IMG_W - 1));
    last_row = (cur_row == RW'(IMG_H - 1));
    top      = sel ? lb1[cur_col] : lb0[cur_col];
    mid      = sel ? lb0[cur_col] : lb1[cur_col];
  end

  // The buffer holding row-2 is overwritten with the current row as it is read
  always_ff @(posedge clk) begin
    if (live) begin
      if (sel) lb1[cur_col] <= s_pix;
      else     lb0[cur_col] <= s_pix;
    end
  end

  // Counters, window shift and interior/end-of-frame tagging
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= 1'b0;
      col     <= '0;
      row     <= '0;
      done    <= 1'b0;
      win_v   <= 1'b0;
      win_eof <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (!stall) begin
      win_v   <= live && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      win_eof <= live && last_row && last_col;
      if (live) begin
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= top;
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= mid;
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= s_pix;
        if (s_sof) done <= 1'b0;
        if (last_col) begin
          col <= '0;
          sel <= ~sel;
          if (last_row) begin
            row  <= '0;
            done <= 1'b1;
          end else begin
            row <= cur_row + RW'(1);
          end
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end
    end
  end

  // Gradients and magnitude, exact in MAG_W+1 signed bits
  always_comb begin
    for (int i = 0; i < 9; i++) e[i] = SW'(win[i]);
    gx_c  = (e[2] + (e[5] <<< 1) + e[8]) - (e[0] + (e[3] <<< 1) + e[6]);
    gy_c  = (e[0] + (e[1] <<< 1) + e[2]) - (e[6] + (e[7] <<< 1) + e[8]);
    ax    = gx[SW-1] ? -gx : gx;
    ay    = gy[SW-1] ? -gy : gy;
    mag_c = MAG_W'(ax + ay);
  end

  // S1 gradients, S2 result registers; everything freezes while the sink stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx      <= '0;
      gy      <= '0;
      s1_v    <= 1'b0;
      s1_eof  <= 1'b0;
      m_valid <= 1'b0;
      m_mag   <= '0;
      m_edge  <= 1'b0;
      m_eof   <= 1'b0;
    end else if (!stall) begin
      gx      <= gx_c;
      gy      <= gy_c;
      s1_v    <= win_v;
      s1_eof  <= win_eof;
      m_valid <= s1_v;
      m_mag   <= mag_c;
      m_edge  <= s1_v && (mag_c > threshold);
      m_eof   <= s1_v && s1_eof;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: random valid/ready streams against an image-array Sobel model.
module tb_sobel_stream;

  localparam int unsigned IMG_W = 8;
  localparam int unsigned IMG_H = 5;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned MAG_W = PIX_W + 3;
  localparam int unsigned RW    = MAG_W + 2;
  localparam int          MAXC  = 20000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid, s_ready, s_sof;
  logic [PIX_W-1:0] s_pix;
  logic [MAG_W-1:0] threshold;
  logic             m_valid, m_ready, m_edge, m_eof;
  logic [MAG_W-1:0] m_mag;

  int checks = 0;
  int errors = 0;

  logic [PIX_W:0]  stim_q [$];
  logic [RW-1:0]   exp_q  [$];
  logic [RW-1:0]   got_q  [$];
  int              img [IMG_H][IMG_W];
  int              mr, mc;
  bit              mdone;

  sobel_stream #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_pix(s_pix), .threshold(threshold), .m_valid(m_valid), .m_ready(m_ready),
    .m_mag(m_mag), .m_edge(m_edge), .m_eof(m_eof)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: store the frame as an image and apply the Sobel kernels at each interior centre
  task automatic model_push(input bit sof, input int pix, input int thr);
    int gx, gy, mag;
    bit eof;
    stim_q.push_back({sof, PIX_W'(pix)});
    if (sof) begin
      mr = 0; mc = 0; mdone = 0;
    end else if (mdone) begin
      return;
    end
    img[mr][mc] = pix;
    if (mr >= 2 && mc >= 2) begin
      gx  = (img[mr-2][mc] + 2*img[mr-1][mc] + img[mr][mc])
          - (img[mr-2][mc-2] + 2*img[mr-1][mc-2] + img[mr][mc-2]);
      gy  = (img[mr-2][mc-2] + 2*img[mr-2][mc-1] + img[mr-2][mc])
          - (img[mr][mc-2] + 2*img[mr][mc-1] + img[mr][mc]);
      mag = iabs(gx) + iabs(gy);
      eof = (mr == IMG_H-1) && (mc == IMG_W-1);
      exp_q.push_back({eof, mag > thr, MAG_W'(mag)});
    end
    if (mc == IMG_W-1) begin
      mc = 0;
      if (mr == IMG_H-1) begin mr = 0; mdone = 1; end
      else mr++;
    end else begin
      mc++;
    end
  endtask

  // kind 0: flat 100, kind 1: vertical step at col 4, kind 2: random
  task automatic push_frame(input int kind, input int thr);
    int pix;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        case (kind)
          0:       pix = 100;
          1:       pix = (c < 4) ? 0 : 255;
          default: pix = int'($urandom_range(255));
        endcase
        model_push(r == 0 && c == 0, pix, thr);
      end
  endtask

  // Stream stim_q with random valid/ready duty, collect results, compare with exp_q
  task automatic run_stream(input int vpct, input int rpct, input string tag);
    int idx, cyc, n;
    bit held;
    logic [RW-1:0] held_v, cur;
    idx = 0; cyc = 0; held = 0; held_v = '0;
    got_q.delete();
    while ((idx < stim_q.size() || got_q.size() < exp_q.size()) && cyc < MAXC) begin
      @(negedge clk);
      s_valid = (idx < stim_q.size()) && ($urandom_range(99) < vpct);
      if (s_valid) {s_sof, s_pix} = stim_q[idx];
      else begin s_sof = 1'b0; s_pix = PIX_W'($urandom); end
      m_ready = ($urandom_range(99) < rpct);
      #1;
      cur = {m_eof, m_edge, m_mag};
      if (held) begin
        check({tag, "_hold_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_hold_data"}, 32'(cur), 32'(held_v));
      end
      held   = m_valid && !m_ready;
      held_v = cur;
      if (m_valid && m_ready) got_q.push_back(cur);
      if (s_valid && s_ready) idx++;
      cyc++;
    end
    check({tag, "_in_budget"}, 32'(cyc < MAXC), 32'd1);
    s_valid = 1'b0; s_sof = 1'b0;
    repeat (8) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      if (m_valid) got_q.push_back({m_eof, m_edge, m_mag});
    end
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_res%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    stim_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int idx, cyc, nedge;
    rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_pix = '0; m_ready = 1'b0;
    threshold = '0; mr = 0; mc = 0; mdone = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_mag", 32'(m_mag), 32'd0);
    check("rst_m_edge", 32'(m_edge), 32'd0);
    check("rst_m_eof", 32'(m_eof), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_s_ready", 32'(s_ready), 32'd1);

    // Flat frame
    threshold = '0;
    push_frame(0, 0);
    run_stream(100, 100, "t1");
    check("t1_n18", 32'(got_q.size()), 32'd18);
    for (int i = 0; i < got_q.size(); i++) begin
      check($sformatf("t1_mag%0d", i), 32'(got_q[i][MAG_W-1:0]), 32'd0);
      check($sformatf("t1_eof%0d", i), 32'(got_q[i][RW-1]), 32'(i == 17));
    end

    // Vertical step, threshold 500
    threshold = MAG_W'(500);
    push_frame(1, 500);
    run_stream(100, 100, "t2");
    for (int i = 0; i < got_q.size(); i++) begin
      int c;
      c = i % 6 + 1;
      check($sformatf("t2_mag%0d", i), 32'(got_q[i][MAG_W-1:0]), (c == 3 || c == 4) ? 32'd1020 : 32'd0);
      check($sformatf("t2_edge%0d", i), 32'(got_q[i][MAG_W]), 32'(c == 3 || c == 4));
    end

    // Strict threshold boundary
    threshold = MAG_W'(1020);
    push_frame(1, 1020);
    run_stream(100, 100, "t3a");
    nedge = 0;
    foreach (got_q[i]) nedge += int'(got_q[i][MAG_W]);
    check("t3a_edges", 32'(nedge), 32'd0);
    threshold = MAG_W'(1019);
    push_frame(1, 1019);
    run_stream(100, 100, "t3b");
    nedge = 0;
    foreach (got_q[i]) nedge += int'(got_q[i][MAG_W]);
    check("t3b_edges", 32'(nedge), 32'd6);

    // Backpressure: 30% ready, random valid, two step frames back to back
    threshold = MAG_W'(500);
    push_frame(1, 500);
    push_frame(1, 500);
    run_stream(70, 30, "t4");
    check("t4_n36", 32'(got_q.size()), 32'd36);

    // s_sof mid-frame at (2,5), then full frame, junk without sof, then another frame
    threshold = MAG_W'(300);
    for (int k = 0; k < 21; k++) model_push(k == 0, int'($urandom_range(255)), 300);
    push_frame(2, 300);
    for (int k = 0; k < 5; k++) model_push(1'b0, int'($urandom_range(255)), 300);
    push_frame(2, 300);
    run_stream(80, 60, "t5");
    check("t5_n39", 32'(got_q.size()), 32'd39);
    if (got_q.size() > 2) check("t5_partial_no_eof", 32'(got_q[2][RW-1]), 32'd0);

    // Async reset while a result is stalled
    threshold = MAG_W'(200);
    push_frame(2, 200);
    idx = 0; cyc = 0;
    while (!m_valid && cyc < 200) begin
      @(negedge clk);
      s_valid = 1'b1;
      {s_sof, s_pix} = stim_q[idx];
      m_ready = 1'b0;
      #1;
      if (s_valid && s_ready) idx++;
      cyc++;
    end
    check("t6_stalled_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_m_valid", 32'(m_valid), 32'd0);
    check("t6_rst_s_ready", 32'(s_ready), 32'd0);
    check("t6_rst_m_mag", 32'(m_mag), 32'd0);
    check("t6_rst_m_eof", 32'(m_eof), 32'd0);
    s_valid = 1'b0; s_sof = 1'b0;
    stim_q.delete(); exp_q.delete();
    mr = 0; mc = 0; mdone = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(2, 200);
    run_stream(90, 80, "t6");
    check("t6_n18", 32'(got_q.size()), 32'd18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
